// File: rtl/dcache_port_arbiter.sv
// -----------------------------------------------------------------------------
// dcache_port_arbiter
//   Shares the single data-cache request port between NumPorts requesters
//   (load unit, store unit, PTW, ...). Round-robin arbitration, with the
//   selection locked onto a requester whose request is waiting for mem_gnt_i.
//   Every accepted transaction (read or write) pushes the requester index into
//   an ID FIFO; in-order dcache responses pop it to route the response strobe.
//
// Ports
//   clk_i, rst_i              clock, asynchronous active-high reset
//   req_valid_i/addr/wdata/we/be/user   per-requester request, port p in slice p
//   req_gnt_o                 one-hot grant, handshake completes this cycle
//   rsp_valid_o               one-hot response strobe
//   rsp_rdata_o, rsp_user_o   shared response data / user field
//   mem_req_o + payload       request towards the dcache
//   mem_gnt_i                 dcache accepts the request this cycle
//   mem_rvalid_i, mem_rdata_i, mem_ruser_i   in-order dcache response
//   busy_o                    transactions outstanding
//   err_o                     sticky: response arrived with no outstanding ID
// -----------------------------------------------------------------------------
module dcache_port_arbiter #(
  parameter int unsigned NumPorts       = 3,
  parameter int unsigned Xlen           = 64,
  parameter int unsigned DataUserEn     = 0,
  parameter int unsigned DataUserWidth  = 64,
  parameter int unsigned MaxOutstanding = 4
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic [NumPorts-1:0]               req_valid_i,
  input  logic [NumPorts*Xlen-1:0]          req_addr_i,
  input  logic [NumPorts*Xlen-1:0]          req_wdata_i,
  input  logic [NumPorts-1:0]               req_we_i,
  input  logic [NumPorts*(Xlen/8)-1:0]      req_be_i,
  input  logic [NumPorts*DataUserWidth-1:0] req_user_i,
  output logic [NumPorts-1:0]               req_gnt_o,
  output logic [NumPorts-1:0]               rsp_valid_o,
  output logic [Xlen-1:0]                   rsp_rdata_o,
  output logic [DataUserWidth-1:0]          rsp_user_o,
  output logic                              mem_req_o,
  output logic [Xlen-1:0]                   mem_addr_o,
  output logic [Xlen-1:0]                   mem_wdata_o,
  output logic                              mem_we_o,
  output logic [Xlen/8-1:0]                 mem_be_o,
  output logic [DataUserWidth-1:0]          mem_user_o,
  input  logic                              mem_gnt_i,
  input  logic                              mem_rvalid_i,
  input  logic [Xlen-1:0]                   mem_rdata_i,
  input  logic [DataUserWidth-1:0]          mem_ruser_i,
  output logic                              busy_o,
  output logic                              err_o
);

  localparam int unsigned IdxW = (NumPorts > 1) ? $clog2(NumPorts) : 1;
  localparam int unsigned PtrW = $clog2(MaxOutstanding);
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned BeW  = Xlen / 8;
  localparam logic [CntW-1:0] MaxCnt   = CntW'(MaxOutstanding);
  localparam logic [IdxW-1:0] LastPort = IdxW'(NumPorts - 1);

  // Arbitration state
  logic [IdxW-1:0] r_rr_ptr;
  logic            r_lock;
  logic [IdxW-1:0] r_lock_idx;

  // ID FIFO state
  logic [IdxW-1:0] r_id_fifo [MaxOutstanding];
  logic [PtrW-1:0] r_head;
  logic [PtrW-1:0] r_tail;
  logic [CntW-1:0] r_count;
  logic            r_err;

  // Combinational decisions
  logic [IdxW-1:0]          w_sel;
  logic                     w_sel_valid;
  logic [31:0]              w_sum;
  logic [IdxW-1:0]          w_idx;
  logic                     w_can_issue;
  logic                     w_mem_req;
  logic                     w_hs;
  logic                     w_pop;
  logic [IdxW-1:0]          w_head_id;
  logic [NumPorts-1:0]      w_gnt;
  logic [NumPorts-1:0]      w_rsp;
  logic [Xlen-1:0]          w_addr;
  logic [Xlen-1:0]          w_wdata;
  logic                     w_we;
  logic [BeW-1:0]           w_be;
  logic [DataUserWidth-1:0] w_user;
  logic [DataUserWidth-1:0] w_ruser;

  // Requester selection: locked index while waiting, else round-robin search
  always_comb begin
    w_sel       = {IdxW{1'b0}};
    w_sel_valid = 1'b0;
    w_sum       = 32'd0;
    w_idx       = {IdxW{1'b0}};
    if (r_lock) begin
      w_sel       = r_lock_idx;
      w_sel_valid = req_valid_i[r_lock_idx];
    end else begin
      // Scan from the pointer upwards; the first hit wins, later hits are ignored.
      for (int unsigned k = 0; k < NumPorts; k++) begin
        w_sum       = 32'(r_rr_ptr) + k;
        w_idx       = (w_sum >= NumPorts) ? IdxW'(w_sum - NumPorts) : IdxW'(w_sum);
        w_sel       = (!w_sel_valid && req_valid_i[w_idx]) ? w_idx : w_sel;
        w_sel_valid = w_sel_valid | req_valid_i[w_idx];
      end
    end
  end

  // The full check uses the registered count, so a same-cycle pop never frees a slot early.
  assign w_can_issue = (r_count < MaxCnt);
  assign w_mem_req   = w_sel_valid && w_can_issue && !rst_i;
  assign w_hs        = w_mem_req && mem_gnt_i;
  assign w_pop       = mem_rvalid_i && (r_count != {CntW{1'b0}}) && !rst_i;
  assign w_head_id   = r_id_fifo[r_head];

  // One-hot grant and response strobes
  always_comb begin
    w_gnt = {NumPorts{1'b0}};
    w_rsp = {NumPorts{1'b0}};
    if (w_hs) begin
      w_gnt[w_sel] = 1'b1;
    end else begin
      w_gnt = {NumPorts{1'b0}};
    end
    if (w_pop) begin
      w_rsp[w_head_id] = 1'b1;
    end else begin
      w_rsp = {NumPorts{1'b0}};
    end
  end

  // Request payload mux from the selected requester, zero during reset
  always_comb begin
    w_addr  = {Xlen{1'b0}};
    w_wdata = {Xlen{1'b0}};
    w_we    = 1'b0;
    w_be    = {BeW{1'b0}};
    w_user  = {DataUserWidth{1'b0}};
    for (int p = 0; p < NumPorts; p++) begin
      w_addr  = (IdxW'(p) == w_sel) ? req_addr_i[p*Xlen +: Xlen]   : w_addr;
      w_wdata = (IdxW'(p) == w_sel) ? req_wdata_i[p*Xlen +: Xlen]  : w_wdata;
      w_we    = (IdxW'(p) == w_sel) ? req_we_i[p]                  : w_we;
      w_be    = (IdxW'(p) == w_sel) ? req_be_i[p*BeW +: BeW]       : w_be;
      w_user  = (IdxW'(p) == w_sel) ? req_user_i[p*DataUserWidth +: DataUserWidth] : w_user;
    end
    if (rst_i) begin
      w_addr  = {Xlen{1'b0}};
      w_wdata = {Xlen{1'b0}};
      w_we    = 1'b0;
      w_be    = {BeW{1'b0}};
      w_user  = {DataUserWidth{1'b0}};
    end else if (DataUserEn == 0) begin
      w_user  = {DataUserWidth{1'b0}};
    end else begin
      w_user  = w_user;
    end
  end

  // Response user field: forwarded only when the user feature is enabled
  always_comb begin
    w_ruser = {DataUserWidth{1'b0}};
    if ((DataUserEn != 0) && !rst_i) begin
      w_ruser = mem_ruser_i;
    end else begin
      w_ruser = {DataUserWidth{1'b0}};
    end
  end

  assign req_gnt_o   = w_gnt;
  assign rsp_valid_o = w_rsp;
  assign rsp_rdata_o = rst_i ? {Xlen{1'b0}} : mem_rdata_i;
  assign rsp_user_o  = w_ruser;
  assign mem_req_o   = w_mem_req;
  assign mem_addr_o  = w_addr;
  assign mem_wdata_o = w_wdata;
  assign mem_we_o    = w_we;
  assign mem_be_o    = w_be;
  assign mem_user_o  = w_user;
  assign busy_o      = (r_count != {CntW{1'b0}});
  assign err_o       = r_err;

  // Round-robin pointer and wait-for-grant lock
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rr_ptr   <= {IdxW{1'b0}};
      r_lock     <= 1'b0;
      r_lock_idx <= {IdxW{1'b0}};
    end else if (w_hs) begin
      r_rr_ptr   <= (w_sel == LastPort) ? {IdxW{1'b0}} : (w_sel + IdxW'(1));
      r_lock     <= 1'b0;
    end else if (w_mem_req) begin
      r_lock     <= 1'b1;
      r_lock_idx <= w_sel;
    end else begin
      // Nothing presented (requester withdrew or idle): fall back to round-robin.
      r_lock     <= 1'b0;
    end
  end

  // ID FIFO: push on handshake, pop on response; error on an unexpected response
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < MaxOutstanding; i++) begin
        r_id_fifo[i] <= {IdxW{1'b0}};
      end
      r_head  <= {PtrW{1'b0}};
      r_tail  <= {PtrW{1'b0}};
      r_count <= {CntW{1'b0}};
      r_err   <= 1'b0;
    end else begin
      if (w_hs) begin
        r_id_fifo[r_tail] <= w_sel;
        r_tail            <= r_tail + PtrW'(1);
      end
      if (w_pop) begin
        r_head <= r_head + PtrW'(1);
      end
      case ({w_hs, w_pop})
        2'b10:   r_count <= r_count + CntW'(1);
        2'b01:   r_count <= r_count - CntW'(1);
        default: r_count <= r_count;
      endcase
      if (mem_rvalid_i && (r_count == {CntW{1'b0}})) begin
        r_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dcache_port_arbiter.sv
module tb_dcache_port_arbiter;
  localparam int N  = 3;
  localparam int XL = 64;
  localparam int UW = 64;
  localparam int MO = 4;
  localparam int BW = XL / 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic [N-1:0]    req_valid, req_we;
  logic [N*XL-1:0] req_addr, req_wdata;
  logic [N*BW-1:0] req_be;
  logic [N*UW-1:0] req_user;
  logic            mem_gnt, mem_rvalid;
  logic [XL-1:0]   mem_rdata;
  logic [UW-1:0]   mem_ruser;

  // DUT with user field enabled
  logic [N-1:0]  req_gnt, rsp_valid;
  logic [XL-1:0] rsp_rdata, mem_addr, mem_wdata;
  logic [UW-1:0] rsp_user, mem_user;
  logic          mem_req, mem_we, busy, err;
  logic [BW-1:0] mem_be;

  // DUT with user field disabled (same stimulus)
  logic [N-1:0]  z_req_gnt, z_rsp_valid;
  logic [XL-1:0] z_rsp_rdata, z_mem_addr, z_mem_wdata;
  logic [UW-1:0] z_rsp_user, z_mem_user;
  logic          z_mem_req, z_mem_we, z_busy, z_err;
  logic [BW-1:0] z_mem_be;

  dcache_port_arbiter #(.NumPorts(N), .Xlen(XL), .DataUserEn(1), .DataUserWidth(UW), .MaxOutstanding(MO)) u_dut (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .req_we_i(req_we), .req_be_i(req_be), .req_user_i(req_user), .req_gnt_o(req_gnt), .rsp_valid_o(rsp_valid),
    .rsp_rdata_o(rsp_rdata), .rsp_user_o(rsp_user), .mem_req_o(mem_req), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_we_o(mem_we), .mem_be_o(mem_be), .mem_user_o(mem_user), .mem_gnt_i(mem_gnt),
    .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata), .mem_ruser_i(mem_ruser), .busy_o(busy), .err_o(err));

  dcache_port_arbiter #(.NumPorts(N), .Xlen(XL), .DataUserEn(0), .DataUserWidth(UW), .MaxOutstanding(MO)) u_dut_nouser (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .req_we_i(req_we), .req_be_i(req_be), .req_user_i(req_user), .req_gnt_o(z_req_gnt), .rsp_valid_o(z_rsp_valid),
    .rsp_rdata_o(z_rsp_rdata), .rsp_user_o(z_rsp_user), .mem_req_o(z_mem_req), .mem_addr_o(z_mem_addr),
    .mem_wdata_o(z_mem_wdata), .mem_we_o(z_mem_we), .mem_be_o(z_mem_be), .mem_user_o(z_mem_user), .mem_gnt_i(mem_gnt),
    .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata), .mem_ruser_i(mem_ruser), .busy_o(z_busy), .err_o(z_err));

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: round-robin pointer, lock, queue of outstanding requester IDs
  int   m_rr;
  bit   m_locked;
  int   m_lock_idx;
  int   m_q[$];
  bit   m_err;
  int   e_sel;
  bit   e_sel_valid;
  logic e_req, e_busy, e_err;
  logic [N-1:0] e_gnt, e_rsp;

  task automatic model_reset();
    m_rr = 0; m_locked = 0; m_lock_idx = 0; m_err = 0;
    m_q.delete();
  endtask

  task automatic model_eval();
    e_sel = 0; e_sel_valid = 0;
    if (m_locked) begin
      e_sel = m_lock_idx;
      e_sel_valid = req_valid[e_sel];
    end else begin
      for (int k = 0; k < N; k++) begin
        int j;
        j = (m_rr + k) % N;
        if (!e_sel_valid && req_valid[j]) begin e_sel = j; e_sel_valid = 1; end
      end
    end
    e_req = e_sel_valid && (m_q.size() < MO);
    e_gnt = '0;
    if (e_req && mem_gnt) e_gnt[e_sel] = 1'b1;
    e_rsp = '0;
    if (mem_rvalid && m_q.size() > 0) e_rsp[m_q[0]] = 1'b1;
    e_busy = (m_q.size() != 0);
    e_err  = m_err;
  endtask

  task automatic model_commit();
    if (mem_rvalid) begin
      if (m_q.size() > 0) void'(m_q.pop_front());
      else m_err = 1;
    end
    if (e_gnt != '0) begin
      m_q.push_back(e_sel);
      m_rr = (e_sel + 1) % N;
      m_locked = 0;
    end else if (e_req) begin
      m_locked = 1; m_lock_idx = e_sel;
    end else begin
      m_locked = 0;
    end
  endtask

  task automatic settle();
    @(negedge clk);
    model_eval();
  endtask

  task automatic tick();
    @(posedge clk);
    model_commit();
    #1;
  endtask

  task automatic clear_inputs();
    req_valid = '0; req_we = '0; req_be = '0; req_user = '0;
    req_addr = '0; req_wdata = '0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0; mem_ruser = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic rand_payload(input int p);
    req_addr[p*XL +: XL]  = {$urandom, $urandom};
    req_wdata[p*XL +: XL] = {$urandom, $urandom};
    req_we[p]             = 1'($urandom);
    req_be[p*BW +: BW]    = 8'($urandom);
    req_user[p*UW +: UW]  = {$urandom, $urandom};
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = '1; mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = {$urandom, $urandom};
    for (int p = 0; p < N; p++) rand_payload(p);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      n_tests++;
      if ({mem_req, req_gnt, rsp_valid, busy, err} !== '0 || rsp_rdata !== '0 || mem_addr !== '0 || mem_user !== '0) begin
        n_fail++;
        $display("FAIL reset_outputs c%0d: got req=%b gnt=%b rsp=%b busy=%b err=%b rdata=%h addr=%h, required all 0",
                 c, mem_req, req_gnt, rsp_valid, busy, err, rsp_rdata, mem_addr);
      end
    end
    do_reset();
  endtask

  task automatic test_round_robin();
    int gseq[$];
    int rseq[$];
    int exp_seq[6] = '{0, 1, 2, 0, 1, 2};
    do_reset();
    for (int p = 0; p < N; p++) rand_payload(p);
    mem_gnt = 1'b1;
    for (int c = 0; c < 8; c++) begin
      req_valid  = (c < 6) ? 3'b111 : 3'b000;
      mem_rvalid = (c >= 2);
      mem_rdata  = {$urandom, $urandom};
      settle();
      n_tests++;
      if (req_gnt !== e_gnt || rsp_valid !== e_rsp || mem_req !== e_req) begin
        n_fail++;
        $display("FAIL rr_cycle c%0d: got gnt=%b rsp=%b req=%b, required gnt=%b rsp=%b req=%b",
                 c, req_gnt, rsp_valid, mem_req, e_gnt, e_rsp, e_req);
      end
      n_tests++;
      if (rsp_rdata !== mem_rdata) begin
        n_fail++;
        $display("FAIL rr_rdata c%0d: got %h required %h", c, rsp_rdata, mem_rdata);
      end
      for (int p = 0; p < N; p++) begin
        if (req_gnt[p]) gseq.push_back(p);
        if (rsp_valid[p]) rseq.push_back(p);
      end
      tick();
    end
    n_tests++;
    if (gseq.size() != 6 || rseq.size() != 6) begin
      n_fail++;
      $display("FAIL rr_counts: got %0d grants %0d responses, required 6 and 6", gseq.size(), rseq.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        n_tests++;
        if (gseq[i] != exp_seq[i] || rseq[i] != exp_seq[i]) begin
          n_fail++;
          $display("FAIL rr_order #%0d: got grant %0d rsp %0d, required %0d", i, gseq[i], rseq[i], exp_seq[i]);
        end
      end
    end
  endtask

  task automatic test_lock();
    logic [N-1:0] exp_gnt[6] = '{3'b000, 3'b000, 3'b000, 3'b010, 3'b001, 3'b000};
    do_reset();
    for (int p = 0; p < N; p++) rand_payload(p);
    for (int c = 0; c < 6; c++) begin
      req_valid[1] = (c <= 3);
      req_valid[0] = (c >= 2 && c <= 4);
      mem_gnt      = (c >= 3);
      settle();
      n_tests++;
      if (req_gnt !== exp_gnt[c] || req_gnt !== e_gnt || mem_req !== e_req) begin
        n_fail++;
        $display("FAIL lock_gnt c%0d: got gnt=%b req=%b, required gnt=%b req=%b", c, req_gnt, mem_req, exp_gnt[c], e_req);
      end
      if (c <= 3) begin
        n_tests++;
        if (mem_addr !== req_addr[XL +: XL] || mem_wdata !== req_wdata[XL +: XL]) begin
          n_fail++;
          $display("FAIL lock_payload c%0d: got addr %h required %h", c, mem_addr, req_addr[XL +: XL]);
        end
      end
      tick();
    end
  endtask

  task automatic test_full();
    do_reset();
    for (int p = 0; p < N; p++) rand_payload(p);
    for (int c = 0; c < 11; c++) begin
      req_valid  = (c < 4) ? 3'b001 : ((c < 7) ? 3'b100 : 3'b000);
      mem_gnt    = 1'b1;
      mem_rvalid = (c == 5) || (c >= 7);
      settle();
      n_tests++;
      if (mem_req !== e_req || req_gnt !== e_gnt || rsp_valid !== e_rsp || busy !== e_busy) begin
        n_fail++;
        $display("FAIL full_cycle c%0d: got req=%b gnt=%b rsp=%b busy=%b, required req=%b gnt=%b rsp=%b busy=%b",
                 c, mem_req, req_gnt, rsp_valid, busy, e_req, e_gnt, e_rsp, e_busy);
      end
      if (c == 4 || c == 5) begin
        n_tests++;
        if (mem_req !== 1'b0) begin
          n_fail++;
          $display("FAIL full_block c%0d: got mem_req %b required 0", c, mem_req);
        end
      end
      if (c == 6) begin
        n_tests++;
        if (mem_req !== 1'b1 || req_gnt !== 3'b100) begin
          n_fail++;
          $display("FAIL full_release: got req=%b gnt=%b required 1 100", mem_req, req_gnt);
        end
      end
      tick();
    end
  endtask

  task automatic test_push_pop_wrap();
    logic [N-1:0] v_tbl[8] = '{3'b010, 3'b100, 3'b001, 3'b010, 3'b100, 3'b001, 3'b000, 3'b000};
    logic [N-1:0] r_tbl[8] = '{3'b000, 3'b000, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100, 3'b001};
    do_reset();
    mem_gnt = 1'b1;
    for (int c = 0; c < 8; c++) begin
      req_valid  = v_tbl[c];
      mem_rvalid = (c >= 2);
      settle();
      n_tests++;
      if (rsp_valid !== r_tbl[c] || rsp_valid !== e_rsp || req_gnt !== v_tbl[c] || busy !== e_busy) begin
        n_fail++;
        $display("FAIL pushpop c%0d: got gnt=%b rsp=%b busy=%b, required gnt=%b rsp=%b busy=%b",
                 c, req_gnt, rsp_valid, busy, v_tbl[c], r_tbl[c], e_busy);
      end
      tick();
    end
    settle();
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL pushpop_drained: got busy %b required 0", busy);
    end
    tick();
  endtask

  task automatic test_err();
    do_reset();
    mem_rvalid = 1'b1;
    settle();
    n_tests++;
    if (rsp_valid !== 3'b000 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL err_drop: got rsp=%b err=%b required 000 0", rsp_valid, err);
    end
    tick();
    mem_rvalid = 1'b0; req_valid = 3'b010; mem_gnt = 1'b1;
    for (int c = 0; c < 3; c++) begin
      settle();
      n_tests++;
      if (err !== 1'b1 || err !== e_err) begin
        n_fail++;
        $display("FAIL err_sticky c%0d: got %b required 1", c, err);
      end
      tick();
    end
    do_reset();
    n_tests++;
    if (err !== 1'b0) begin
      n_fail++;
      $display("FAIL err_clear: got %b required 0", err);
    end
    // Outstanding transaction discarded by reset; its late response is unexpected.
    req_valid = 3'b001; mem_gnt = 1'b1;
    settle(); tick();
    do_reset();
    mem_rvalid = 1'b1;
    settle();
    n_tests++;
    if (rsp_valid !== 3'b000 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL err_midreset_rsp: got rsp=%b busy=%b required 000 0", rsp_valid, busy);
    end
    tick();
    mem_rvalid = 1'b0;
    settle();
    n_tests++;
    if (err !== 1'b1) begin
      n_fail++;
      $display("FAIL err_midreset_flag: got %b required 1", err);
    end
    tick();
  endtask

  task automatic test_user();
    do_reset();
    for (int p = 0; p < N; p++) rand_payload(p);
    req_user[2*UW +: UW] = 64'hA5;
    req_valid = 3'b100; mem_gnt = 1'b1;
    settle();
    n_tests++;
    if (mem_user !== 64'hA5 || z_mem_user !== 64'h0 || req_gnt !== 3'b100) begin
      n_fail++;
      $display("FAIL user_req: got user=%h nouser=%h gnt=%b required a5 0 100", mem_user, z_mem_user, req_gnt);
    end
    tick();
    req_valid = 3'b000; mem_rvalid = 1'b1; mem_ruser = 64'h3C;
    settle();
    n_tests++;
    if (rsp_user !== 64'h3C || z_rsp_user !== 64'h0 || rsp_valid !== 3'b100) begin
      n_fail++;
      $display("FAIL user_rsp: got user=%h nouser=%h rsp=%b required 3c 0 100", rsp_user, z_rsp_user, rsp_valid);
    end
    tick();
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      for (int p = 0; p < N; p++) begin
        if (!req_valid[p] && ($urandom_range(0, 99) < 40)) begin
          rand_payload(p);
          req_valid[p] = 1'b1;
        end
      end
      mem_gnt    = ($urandom_range(0, 99) < 70);
      mem_rvalid = (m_q.size() > 0) && ($urandom_range(0, 99) < 50);
      mem_rdata  = {$urandom, $urandom};
      mem_ruser  = {$urandom, $urandom};
      settle();
      n_tests++;
      if (mem_req !== e_req || req_gnt !== e_gnt || rsp_valid !== e_rsp || busy !== e_busy || err !== e_err) begin
        n_fail++;
        $display("FAIL rand_ctrl c%0d: got req=%b gnt=%b rsp=%b busy=%b err=%b, required req=%b gnt=%b rsp=%b busy=%b err=%b",
                 c, mem_req, req_gnt, rsp_valid, busy, err, e_req, e_gnt, e_rsp, e_busy, e_err);
      end
      if (e_req) begin
        n_tests++;
        if (mem_addr !== req_addr[e_sel*XL +: XL] || mem_wdata !== req_wdata[e_sel*XL +: XL] ||
            mem_we !== req_we[e_sel] || mem_be !== req_be[e_sel*BW +: BW] ||
            mem_user !== req_user[e_sel*UW +: UW] || z_mem_user !== '0) begin
          n_fail++;
          $display("FAIL rand_payload c%0d: got addr=%h we=%b be=%h, required port %0d addr=%h we=%b be=%h",
                   c, mem_addr, mem_we, mem_be, e_sel, req_addr[e_sel*XL +: XL], req_we[e_sel], req_be[e_sel*BW +: BW]);
        end
      end
      n_tests++;
      if (rsp_rdata !== mem_rdata || rsp_user !== mem_ruser || z_rsp_user !== '0) begin
        n_fail++;
        $display("FAIL rand_rsp_data c%0d: got %h/%h required %h/%h", c, rsp_rdata, rsp_user, mem_rdata, mem_ruser);
      end
      tick();
      for (int p = 0; p < N; p++) begin
        if (e_gnt[p]) req_valid[p] = 1'b0;
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    clear_inputs();
    model_reset();
    test_reset();
    test_round_robin();
    test_lock();
    test_full();
    test_push_pop_wrap();
    test_err();
    test_user();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
